cpu_host_ctrl: RTL and testbench

Host-side sequencer that drives the cpu top's loading/run interface (status, data_in, data_addr_in) and consumes its outputs (end_process, data_out). It streams an instruction image and then a data image from a byte source into the cpu, releases the cpu to run, waits for end_process with a timeout, and then reads back a window of data memory onto a byte output stream. It sits between the board/test harness and cpu, in the same clk domain.

---
 rtl/cpu_host_ctrl_if.sv | 32 +++
 rtl/cpu_host_ctrl.sv | 129 ++++++++++++
 tb/tb_cpu_host_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_host_ctrl_if.sv
// Host-controller bundle: job control, source byte stream, cpu load/run port
// and readback byte stream. master = controller side.
interface cpu_host_ctrl_if;
  logic        start;
  logic        src_valid;
  logic [7:0]  src_data;
  logic        src_ready;
  logic [1:0]  status;
  logic [7:0]  data_in;
  logic [15:0] data_addr_in;
  logic        end_process;
  logic [7:0]  data_out;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [15:0] rd_addr;
  logic        rd_ready;
  logic        busy;
  logic        done;
  logic        timeout_err;

  modport master (
    input  start, src_valid, src_data, end_process, data_out, rd_ready,
    output src_ready, status, data_in, data_addr_in,
           rd_valid, rd_data, rd_addr, busy, done, timeout_err
  );

  modport slave (
    output start, src_valid, src_data, end_process, data_out, rd_ready,
    input  src_ready, status, data_in, data_addr_in,
           rd_valid, rd_data, rd_addr, busy, done, timeout_err
  );
endinterface

// File: rtl/cpu_host_ctrl.sv
// Host sequencer for the cpu: loads IM then DM images from a byte source,
// runs the cpu with a timeout, then streams a data-memory window back out.
module cpu_host_ctrl #(
  parameter int IM_BYTES = 512,
  parameter int DM_BYTES = 256,
  parameter int RD_BASE  = 0,
  parameter int RD_BYTES = 256,
  parameter int TIMEOUT  = 1000000
) (
  input logic             clk,
  input logic             rst_n,
  cpu_host_ctrl_if.master bus
);
  localparam logic [1:0]  ST_HOLD  = 2'b00;
  localparam logic [1:0]  ST_IM    = 2'b01;
  localparam logic [1:0]  ST_DM    = 2'b10;
  localparam logic [1:0]  ST_RUN   = 2'b11;
  localparam logic [15:0] IM_LAST  = 16'(IM_BYTES - 1);
  localparam logic [15:0] DM_LAST  = 16'(DM_BYTES - 1);
  localparam logic [15:0] RD_FIRST = 16'(RD_BASE);
  localparam logic [31:0] RD_LAST  = 32'(RD_BYTES - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_IM, S_LOAD_DM, S_RUN,
    S_RD_ADDR, S_RD_CAPT, S_RD_XFER, S_DONE, S_ERR
  } state_t;

  state_t      state;
  logic [15:0] addr;
  logic [31:0] cnt;   // RUN timer, then readback byte count

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      addr             <= '0;
      cnt              <= '0;
      bus.src_ready    <= 1'b0;
      bus.status       <= ST_HOLD;
      bus.data_in      <= '0;
      bus.data_addr_in <= '0;
      bus.rd_valid     <= 1'b0;
      bus.rd_data      <= '0;
      bus.rd_addr      <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.timeout_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            state           <= S_LOAD_IM;
            addr            <= '0;
            bus.src_ready   <= 1'b1;
            bus.busy        <= 1'b1;
            bus.done        <= 1'b0;
            bus.timeout_err <= 1'b0;
          end
        end
        S_LOAD_IM, S_LOAD_DM: begin
          // cpu writes on every 01/10 cycle, so only a fresh byte may carry one
          bus.status <= ST_HOLD;
          if (bus.src_valid && bus.src_ready) begin
            bus.status       <= (state == S_LOAD_IM) ? ST_IM : ST_DM;
            bus.data_in      <= bus.src_data;
            bus.data_addr_in <= addr;
            addr             <= addr + 16'd1;
            if (state == S_LOAD_IM && addr == IM_LAST) begin
              addr <= '0;
              if (DM_BYTES == 0) begin
                state         <= S_RUN;
                bus.src_ready <= 1'b0;
                cnt           <= '0;
              end else begin
                state <= S_LOAD_DM;
              end
            end else if (state == S_LOAD_DM && addr == DM_LAST) begin
              state         <= S_RUN;
              bus.src_ready <= 1'b0;
              cnt           <= '0;
            end
          end
        end
        S_RUN: begin
          // first RUN cycle still carries the final write; timer starts once cpu sees 11
          if (bus.status != ST_RUN) begin
            bus.status <= ST_RUN;
          end else if (bus.end_process) begin
            state            <= S_RD_ADDR;
            bus.status       <= ST_HOLD;
            addr             <= RD_FIRST;
            bus.data_addr_in <= RD_FIRST;
            cnt              <= '0;
          end else if (cnt == TO_LAST) begin
            state           <= S_ERR;
            bus.status      <= ST_HOLD;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_RD_ADDR: state <= S_RD_CAPT;
        S_RD_CAPT: begin
          bus.rd_data  <= bus.data_out;
          bus.rd_addr  <= addr;
          bus.rd_valid <= 1'b1;
          state        <= S_RD_XFER;
        end
        S_RD_XFER: begin
          if (bus.rd_ready) begin
            bus.rd_valid <= 1'b0;
            if (cnt == RD_LAST) begin
              state    <= S_DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              cnt              <= cnt + 32'd1;
              addr             <= addr + 16'd1;
              bus.data_addr_in <= addr + 16'd1;
              state            <= S_RD_ADDR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_host_ctrl.sv
// Scoreboard bench for cpu_host_ctrl: cpu writes and readback bytes are
// predicted when driven and checked as the controller produces them.
module tb_cpu_host_ctrl;
  localparam int IM = 4;
  localparam int DM = 2;
  localparam int RB = 16;
  localparam int RN = 3;
  localparam int TO = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_host_ctrl_if bus ();

  cpu_host_ctrl #(
    .IM_BYTES(IM), .DM_BYTES(DM), .RD_BASE(RB), .RD_BYTES(RN), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // cpu data memory: synchronous read, fixed contents in the readback window
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h0010: return 8'hA1;
      16'h0011: return 8'hA2;
      16'h0012: return 8'hA3;
      default:  return 8'h00;
    endcase
  endfunction

  always @(posedge clk) bus.data_out <= mem_rd(bus.data_addr_in);

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] wr_q[$];
  logic [23:0] rd_q[$];
  logic [7:0]  img[IM+DM];
  int hs_cnt, gap_cnt;
  logic wr_seen, run_follow;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {26'h0, bus.status, bus.src_ready, bus.rd_valid, bus.busy, bus.done}, 32'h0);
    chk({tag, "_err"}, {31'h0, bus.timeout_err}, 32'h0);
    chk({tag, "_din"}, {8'h0, bus.data_in, bus.data_addr_in}, 32'h0);
    chk({tag, "_rd"},  {8'h0, bus.rd_data, bus.rd_addr}, 32'h0);
  endtask

  task automatic monitor();
    logic        prev_wr = 1'b0;
    logic        hold_prev = 1'b0;
    logic        wr;
    logic [31:0] hold_val = '0;
    logic [31:0] e;
    logic [23:0] r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_wr = 1'b0;
        hold_prev = 1'b0;
      end else begin
        wr = (bus.status == 2'b01) || (bus.status == 2'b10);
        if (wr) begin
          if (wr_q.size() == 0)
            chk("wr_extra", {14'h0, bus.status, bus.data_addr_in}, 32'hFFFF_FFFF);
          else begin
            e = wr_q.pop_front();
            chk("wr", {6'h0, bus.status, bus.data_addr_in, bus.data_in}, e);
          end
          wr_seen = 1'b1;
        end else begin
          if (wr_seen && wr_q.size() > 0 && bus.status == 2'b00) gap_cnt++;
          if (run_follow && prev_wr && wr_q.size() == 0) chk("run_after_load", bus.status, 3);
        end
        prev_wr = wr;
        if (hold_prev) chk("rd_hold", {7'h0, bus.rd_valid, bus.rd_addr, bus.rd_data}, hold_val);
        hold_prev = bus.rd_valid && !bus.rd_ready;
        if (hold_prev) begin
          hold_val = {7'h0, 1'b1, bus.rd_addr, bus.rd_data};
          if (rd_q.size() > 0) chk("rd_addr_hold", bus.data_addr_in, rd_q[0][23:8]);
        end
        if (bus.rd_valid && bus.rd_ready) begin
          if (rd_q.size() == 0)
            chk("rd_extra", {8'h0, bus.rd_addr, bus.rd_data}, 32'hFFFF_FFFF);
          else begin
            r = rd_q.pop_front();
            chk("rd", {8'h0, bus.rd_addr, bus.rd_data}, {8'h0, r});
          end
        end
        if (bus.src_valid && bus.src_ready) hs_cnt++;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
  endtask

  // offers n image bytes, optionally with valid toggling 1,0,1,0
  task automatic load_img(input int n, input bit gaps);
    int i = 0, k = 0, g = 0;
    for (int j = 0; j < n; j++) begin
      img[j] = 8'($urandom);
      wr_q.push_back({6'h0, (j < IM) ? 2'b01 : 2'b10, 16'((j < IM) ? j : j - IM), img[j]});
    end
    while (i < n && g < 100) begin
      @(posedge clk); #2;
      bus.src_valid = gaps ? (k % 2 == 0) : 1'b1;
      k++;
      bus.src_data = img[i];
      @(negedge clk); g++;
      if (bus.src_valid && bus.src_ready) i++;
    end
    chk("load_accepted", i, n);
    @(posedge clk); #2 bus.src_data = 8'hEE;
  endtask

  // end_at = status-11 cycle on which end_process is raised; 0 = never
  task automatic run_job(input bit gaps, input int end_at, input int hold, output int n_run);
    int g;
    wr_seen = 1'b0; gap_cnt = 0; hs_cnt = 0;
    bus.src_valid = 1'b0;
    pulse_start();
    chk("busy_job", bus.busy, 1);
    load_img(IM + DM, gaps);
    n_run = 0; g = 0;
    while (!bus.timeout_err && g < 200 && !(end_at > 0 && n_run == end_at)) begin
      @(negedge clk); g++;
      if (bus.status == 2'b11) n_run++;
    end
    if (end_at > 0) begin
      bus.end_process = 1'b1;
      for (int j = 0; j < RN; j++) rd_q.push_back({16'(RB + j), 8'(8'hA1 + j)});
      @(posedge clk); #2;
      bus.end_process = 1'b0;
      bus.rd_ready = (hold == 0);
      if (hold > 0) begin
        g = 0;
        while (!bus.rd_valid && g < 20) begin @(negedge clk); g++; end
        chk("rd_first_seen", bus.rd_valid, 1);
        repeat (hold - 1) @(negedge clk);
        @(posedge clk); #2 bus.rd_ready = 1'b1;
      end
      g = 0;
      while (!bus.done && g < 60) begin @(negedge clk); g++; end
      chk("done", bus.done, 1);
      chk("busy_done", bus.busy, 0);
      chk("rdq_empty", rd_q.size(), 0);
    end
    @(posedge clk); #2 bus.src_valid = 1'b0;
    chk("hs_count", hs_cnt, IM + DM);
    chk("wrq_empty", wr_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start = 1'b0; bus.src_valid = 1'b0; bus.src_data = '0;
    bus.end_process = 1'b0; bus.rd_ready = 1'b1;
    wr_seen = 1'b0; run_follow = 1'b1; hs_cnt = 0; gap_cnt = 0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    // always-valid source, normal run and readback
    run_job(1'b0, 50, 0, n);
    chk("run_cycles", n, 50);
    chk("gaps_contig", gap_cnt, 0);
    chk("status_done", bus.status, 0);

    // toggling source, readback sink stalls on the first byte
    run_job(1'b1, 5, 5, n);
    chk("gaps_toggle", gap_cnt, 5);

    // no end_process: timeout after exactly TO run cycles
    run_job(1'b0, 0, 0, n);
    chk("to_cycles", n, TO);
    chk("to_err", bus.timeout_err, 1);
    chk("to_status", bus.status, 0);
    chk("to_busy", bus.busy, 0);
    chk("to_done", bus.done, 0);

    // end_process on the expiry cycle wins over timeout
    run_job(1'b0, TO, 0, n);
    chk("edge_no_err", bus.timeout_err, 0);

    // reset during LOAD_DM, then a clean reload from IM address 0
    run_follow = 1'b0; hs_cnt = 0; wr_seen = 1'b0;
    pulse_start();
    load_img(IM + 1, 1'b0);
    bus.src_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    chk("mid_hs", hs_cnt, IM + 1);
    chk("mid_wrq", wr_q.size(), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    run_follow = 1'b1;
    run_job(1'b0, 5, 0, n);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
